// File: rtl/mux_demux_scheduler_pkg.sv
// Shared types and helpers for the mux/demux path scheduler.
package mux_demux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest lane count the one-hot helper can encode.
  localparam int unsigned MAX_LANES = 64;

  // Select width for an n-way index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_LANES-1:0] onehot(input int unsigned idx);
    return MAX_LANES'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_demux_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after rr_ptr, wrapping.
module rr_arbiter
  import mux_demux_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   rr_ptr,
  output logic [idx_w(N)-1:0]   gnt_idx,
  output logic                  gnt_valid
);

  localparam int unsigned IW = idx_w(N);

  // Scan N candidates starting one past the last winner; first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!gnt_valid && req[(32'(rr_ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((32'(rr_ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mux_demux_scheduler.sv
// Time-shares the N-to-M mux/demux datapath: arbitrates one source, holds its
// path for BURST beats (stalling on destination backpressure), pulses done.
module mux_demux_scheduler
  import mux_demux_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic [N*idx_w(M)-1:0]     dest,
  input  logic [M-1:0]              dst_ready,
  output logic [idx_w(N)-1:0]       sel_mux,
  output logic [idx_w(M)-1:0]       sel_demux,
  output logic [N-1:0]              grant,
  output logic                      path_en,
  output logic [N-1:0]              done,
  output logic                      busy
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned SW = idx_w(M);
  localparam int unsigned CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   sel_mux_q, sel_mux_d;
  logic [SW-1:0]   sel_demux_q, sel_demux_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [CW-1:0]   beat_q, beat_d;

  logic [IW-1:0]   arb_idx;
  logic            arb_valid;

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // The winner is identified by sel_mux_q for the whole grant.
  assign path_en   = (state_q == XFER) && dst_ready[sel_demux_q];
  assign done      = (state_q == DONE) ? grant_q : '0;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign sel_mux   = sel_mux_q;
  assign sel_demux = sel_demux_q;

  // Next-state: arbitration, settle, beat counting, abort and completion.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_mux_d   = sel_mux_q;
    sel_demux_d = sel_demux_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d     = SETUP;
          grant_d     = N'(onehot(32'(arb_idx)));
          sel_mux_d   = arb_idx;
          sel_demux_d = dest[arb_idx*SW +: SW];
        end
      end
      SETUP, XFER: begin
        // Withdrawn request beats a final beat on the same edge: no done.
        if (!req[sel_mux_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          beat_d   = '0;
          rr_ptr_d = sel_mux_q;
        end else if (state_q == SETUP) begin
          state_d = XFER;
        end else if (path_en) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = sel_mux_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; rr_ptr resets to N-1 so source 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(N - 1);
      sel_mux_q   <= '0;
      sel_demux_q <= '0;
      grant_q     <= '0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_mux_q   <= sel_mux_d;
      sel_demux_q <= sel_demux_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
    end
  end

endmodule

// File: tb/tb_mux_demux_scheduler.sv
// Self-checking bench for mux_demux_scheduler (BURST=4 main, BURST=1 corner).
module tb_mux_demux_scheduler;

  localparam int unsigned N     = 8;
  localparam int unsigned M     = 8;
  localparam int unsigned BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  req_a = '0;
  logic [23:0] dest_a = '0;
  logic [7:0]  rdy_a = 8'hFF;
  logic [2:0]  sel_mux_a, sel_demux_a;
  logic [7:0]  grant_a, done_a;
  logic        path_en_a, busy_a;

  logic [7:0]  req_b = '0;
  logic [23:0] dest_b = '0;
  logic [7:0]  rdy_b = 8'hFF;
  logic [2:0]  sel_mux_b, sel_demux_b;
  logic [7:0]  grant_b, done_b;
  logic        path_en_b, busy_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [7:0]  g;
    logic [2:0]  mux;
    logic [2:0]  demux;
    int unsigned busy_len;
    int unsigned gap;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] req;
    logic [2:0] dw;
    logic [7:0] g;
    logic [2:0] mux;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  mux_demux_scheduler #(.N(N), .M(M), .BURST(BURST)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .dest(dest_a), .dst_ready(rdy_a),
    .sel_mux(sel_mux_a), .sel_demux(sel_demux_a), .grant(grant_a),
    .path_en(path_en_a), .done(done_a), .busy(busy_a)
  );

  mux_demux_scheduler #(.N(N), .M(M), .BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .dest(dest_b), .dst_ready(rdy_b),
    .sel_mux(sel_mux_b), .sel_demux(sel_demux_b), .grant(grant_b),
    .path_en(path_en_b), .done(done_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_grant_a(input int unsigned budget);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant_a == 8'h00 && n < budget);
  endtask

  task automatic wait_done_a(input int unsigned budget);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_a == 8'h00 && n < budget);
    check("done_seen", {31'b0, done_a != 8'h00}, 32'd1);
  endtask

  task automatic wait_beats_a(input int unsigned k);
    int unsigned n = 0;
    int unsigned t = 0;
    while (n < k && t < 20) begin
      @(negedge clk);
      t++;
      if (path_en_a) n++;
    end
    check("beats_reached", n, k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_grant_a", grant_a, 0);
    check("rst_mux_a", sel_mux_a, 0);
    check("rst_demux_a", sel_demux_a, 0);
    check("rst_pe_a", path_en_a, 0);
    check("rst_done_a", done_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_grant_b", grant_b, 0);
    check("rst_busy_b", busy_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each done pulse and checks the burst shape.
  initial begin
    int unsigned cyc = 0;
    int unsigned last_done = 0;
    int unsigned busy_cnt = 0;
    int unsigned beats = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        busy_cnt = 0;
        beats = 0;
      end else begin
        busy_cnt = busy_a ? busy_cnt + 1 : 0;
        if (path_en_a) beats++;
        if (done_a != 8'h00) begin
          if (sb.size() == 0) begin
            check("done_unexpected", done_a, 0);
          end else begin
            e = sb.pop_front();
            check("sb_done", done_a, e.g);
            check("sb_grant", grant_a, e.g);
            check("sb_mux", sel_mux_a, e.mux);
            check("sb_demux", sel_demux_a, e.demux);
            check("sb_beats", beats, BURST);
            check("sb_busy_len", busy_cnt, e.busy_len);
            check("sb_pe_in_done", path_en_a, 0);
            if (e.gap != 0) check("sb_done_gap", cyc - last_done, e.gap);
          end
          last_done = cyc;
        end
        if (!busy_a) beats = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h04, 3'd5, 8'h04, 3'd2};
    vt[1] = '{8'h81, 3'd3, 8'h80, 3'd7};
    vt[2] = '{8'h81, 3'd0, 8'h01, 3'd0};
    vt[3] = '{8'h30, 3'd1, 8'h10, 3'd4};
    vt[4] = '{8'h11, 3'd6, 8'h01, 3'd0};
    vt[5] = '{8'h20, 3'd7, 8'h20, 3'd5};

    do_reset();

    // Table: single grants with round-robin priority carried between vectors.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_a  = vt[i].req;
      dest_a = {8{vt[i].dw}};
      wait_grant_a(8);
      check("vec_grant", grant_a, vt[i].g);
      check("vec_mux", sel_mux_a, vt[i].mux);
      check("vec_demux", sel_demux_a, vt[i].dw);
      check("vec_setup_pe", path_en_a, 0);
      sb.push_back('{vt[i].g, vt[i].mux, vt[i].dw, BURST + 2, 0});
      dest_a = {8{~vt[i].dw}};
      wait_done_a(20);
      req_a = '0;
    end

    // Backpressure: destination 5 not ready for 3 cycles after beat 2.
    @(negedge clk);
    req_a  = 8'h04;
    dest_a = {8{3'd5}};
    wait_grant_a(8);
    check("stall_grant", grant_a, 8'h04);
    sb.push_back('{8'h04, 3'd2, 3'd5, BURST + 5, 0});
    wait_beats_a(2);
    @(posedge clk);
    #1 rdy_a = 8'hDF;
    repeat (3) begin
      @(negedge clk);
      check("stall_pe", path_en_a, 0);
      check("stall_busy", busy_a, 1);
    end
    @(posedge clk);
    #1 rdy_a = 8'hFF;
    wait_done_a(20);
    req_a = '0;

    // All sources requesting: strict rotation, done pulses BURST+3 apart.
    @(negedge clk);
    do_reset();
    @(negedge clk);
    dest_a = '0;
    req_a  = 8'hFF;
    for (int k = 0; k < 9; k++)
      sb.push_back('{8'(1 << (k % 8)), 3'(k % 8), 3'd0, BURST + 2, (k == 0) ? 0 : BURST + 3});
    for (int k = 0; k < 9; k++) wait_done_a(20);
    req_a = '0;

    // Abort: source 2 withdraws after 2 beats; source 3 follows; 2 wins after 3.
    @(negedge clk);
    req_a  = 8'h0C;
    dest_a = {8{3'd4}};
    wait_grant_a(8);
    check("abort_grant", grant_a, 8'h04);
    wait_beats_a(2);
    @(posedge clk);
    #1 req_a = 8'h08;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    check("abort_grant_clr", grant_a, 0);
    sb.push_back('{8'h08, 3'd3, 3'd4, BURST + 2, 0});
    wait_grant_a(8);
    check("after_abort_grant", grant_a, 8'h08);
    req_a = 8'h0C;
    sb.push_back('{8'h04, 3'd2, 3'd4, BURST + 2, 0});
    wait_done_a(20);
    wait_grant_a(8);
    check("rereq_grant", grant_a, 8'h04);
    wait_done_a(20);
    req_a = '0;

    // Asynchronous reset mid-transfer, then priority restarts at source 0.
    @(negedge clk);
    req_a  = 8'h01;
    dest_a = {8{3'd1}};
    wait_grant_a(8);
    wait_beats_a(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant", grant_a, 0);
    check("midrst_mux", sel_mux_a, 0);
    check("midrst_demux", sel_demux_a, 0);
    check("midrst_pe", path_en_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_busy", busy_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_a = 8'h81;
    sb.push_back('{8'h01, 3'd0, 3'd1, BURST + 2, 0});
    wait_grant_a(8);
    check("postrst_grant", grant_a, 8'h01);
    wait_done_a(20);
    req_a = '0;

    // Single-beat burst to the highest destination.
    @(negedge clk);
    req_b  = 8'h01;
    dest_b = {8{3'd7}};
    @(negedge clk);
    check("b1_grant", grant_b, 8'h01);
    check("b1_demux", sel_demux_b, 3'd7);
    check("b1_setup_pe", path_en_b, 0);
    @(negedge clk);
    check("b1_beat_pe", path_en_b, 1);
    check("b1_beat_done", done_b, 0);
    @(negedge clk);
    check("b1_done", done_b, 8'h01);
    check("b1_done_pe", path_en_b, 0);
    req_b = '0;
    @(negedge clk);
    check("b1_idle_busy", busy_b, 0);
    check("b1_idle_done", done_b, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
